// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter among N_REQ byte sources,
// with burst lock, inter-byte gap and a sticky tx_done timeout flag.
module uart_tx_sched #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned GAP_CLK     = 2,
  parameter int unsigned TIMEOUT_CLK = 1000000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ-1:0]   lock_i,
  input  logic [8*N_REQ-1:0] din_i,
  input  logic               tx_done_i,
  input  logic               err_clr_i,
  output logic               tx_start_o,
  output logic [7:0]         tx_dat_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [N_REQ-1:0]   ack_o,
  output logic               err_tout_o
);

  localparam int unsigned SW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TW       = $clog2(TIMEOUT_CLK + 1);
  localparam int unsigned GW       = (GAP_CLK > 0) ? $clog2(GAP_CLK + 1) : 1;
  localparam int unsigned GAP_LAST = (GAP_CLK > 0) ? GAP_CLK - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_dat_q, tx_dat_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             err_q, err_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;

  logic [7:0]       din_a [N_REQ];
  logic             pick_vld;
  logic [SW-1:0]    pick_idx;
  logic [SW-1:0]    ptr_nxt;

  for (genvar g = 0; g < N_REQ; g++) begin : g_din
    assign din_a[g] = din_i[8*g +: 8];
  end

  // First set request scanning upward from the round-robin pointer
  always_comb begin : rr_pick
    int unsigned idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!pick_vld && req_i[SW'(idx)]) begin
        pick_vld = 1'b1;
        pick_idx = SW'(idx);
      end
    end
  end

  assign ptr_nxt = (sel_q == SW'(N_REQ - 1)) ? '0 : sel_q + SW'(1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    tx_start_d = 1'b0;
    tx_dat_d   = tx_dat_q;
    grant_d    = grant_q;
    ack_d      = '0;
    err_d      = err_q;
    tcnt_d     = tcnt_q;
    gcnt_d     = gcnt_q;

    if (err_clr_i) begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          sel_d      = pick_idx;
          tx_dat_d   = din_a[pick_idx];
          grant_d    = N_REQ'(1) << pick_idx;
          tx_start_d = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end
      // tx_done takes priority over a coincident timeout
      ST_WAIT: begin
        if (tx_done_i) begin
          ack_d   = grant_q;
          gcnt_d  = '0;
          state_d = ST_GAP;
        end else if (tcnt_q == TW'(TIMEOUT_CLK - 1)) begin
          err_d   = 1'b1;
          gcnt_d  = '0;
          state_d = ST_GAP;
        end else if (tcnt_q != TW'(TIMEOUT_CLK)) begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_GAP: begin
        if (gcnt_q == GW'(GAP_LAST)) begin
          if (lock_i[sel_q] && req_i[sel_q]) begin
            tx_dat_d   = din_a[sel_q];
            tx_start_d = 1'b1;
            state_d    = ST_SEND;
          end else begin
            grant_d = '0;
            ptr_d   = ptr_nxt;
            state_d = ST_IDLE;
          end
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      tx_start_q <= 1'b0;
      tx_dat_q   <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
      gcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      tx_start_q <= tx_start_d;
      tx_dat_q   <= tx_dat_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
      gcnt_q     <= gcnt_d;
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_dat_o   = tx_dat_q;
  assign grant_o    = grant_q;
  assign ack_o      = ack_q;
  assign err_tout_o = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: requester and transmitter models drive the DUT,
// a monitor checks every tx_start and ack against queued expectations.
module tb_uart_tx_sched;

  localparam int unsigned N    = 4;
  localparam int unsigned GAP  = 2;
  localparam int unsigned TOUT = 600;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic [8*N-1:0] din;
  logic         tx_done;
  logic         tx_done_m;
  logic         tx_done_s;
  logic         err_clr;
  logic         tx_start;
  logic [7:0]   tx_dat;
  logic [N-1:0] grant;
  logic [N-1:0] ack;
  logic         err_tout;

  assign tx_done = tx_done_m | tx_done_s;

  uart_tx_sched #(.N_REQ(N), .GAP_CLK(GAP), .TIMEOUT_CLK(TOUT)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .din_i(din),
    .tx_done_i(tx_done), .err_clr_i(err_clr), .tx_start_o(tx_start),
    .tx_dat_o(tx_dat), .grant_o(grant), .ack_o(ack), .err_tout_o(err_tout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    logic [7:0]   dat;
    int           dly;
    bit           from_done;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] ack_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int mark_cyc = 0;
  int done_cyc = 0;
  logic [7:0] last_dat = '0;

  int        frame_len = 10;
  int        tx_mode   = 0;
  int        tx_rem;
  logic [7:0] src_dat [N][4];
  int        src_idx  [N] = '{default: 0};
  int        src_left [N] = '{default: 0};
  bit        src_lock [N] = '{default: 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic load(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input bit lk);
    src_dat[i][0] = b0;
    src_dat[i][1] = b1;
    src_dat[i][2] = b2;
    src_dat[i][3] = 8'h00;
    src_idx[i]    = 0;
    src_left[i]   = n;
    src_lock[i]   = lk;
  endtask

  task automatic expect_byte(input logic [N-1:0] g, input logic [7:0] d, input int dly,
                             input bit fd, input bit acked);
    exp_t e;
    e.grant = g;
    e.dat = d;
    e.dly = dly;
    e.from_done = fd;
    exp_q.push_back(e);
    if (acked) ack_q.push_back(g);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || ack_q.size() != 0 || grant != '0 || req != '0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL drain: pending starts=%0d acks=%0d grant=%b req=%b, expected all empty",
               exp_q.size(), ack_q.size(), grant, req);
    end
  endtask

  task automatic wait_start(input int budget);
    int k;
    k = 0;
    while (!tx_start && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_start", 32'(tx_start), 32'd1);
  endtask

  // Requesters: hold req until their bytes are acked, advance din per ack
  initial begin
    req  = '0;
    lock = '0;
    din  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ack[i] && src_left[i] > 0) begin
          src_left[i]--;
          src_idx[i]++;
        end
        req[i]         = (src_left[i] > 0);
        lock[i]        = src_lock[i] && (src_left[i] > 0);
        din[8*i +: 8]  = src_dat[i][src_idx[i] % 4];
      end
    end
  end

  // Transmitter: tx_done frame_len cycles after tx_start, or never when tx_mode=1
  initial begin
    tx_done_m = 1'b0;
    tx_rem    = -1;
    forever begin
      @(posedge clk);
      #1;
      tx_done_m = 1'b0;
      if (rst) tx_rem = -1;
      else if (tx_rem == 0) begin
        tx_done_m = 1'b1;
        tx_rem = -1;
      end else if (tx_rem > 0) tx_rem--;
      if (!rst && tx_start && tx_mode == 0) tx_rem = frame_len - 1;
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (exp_q.size() == 0) chk("start_unexpected", 32'(grant), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("start_grant", 32'(grant), 32'(e.grant));
          chk("start_dat", 32'(tx_dat), 32'(e.dat));
          if (e.dly >= 0)
            chk("start_lat", 32'(cyc - (e.from_done ? done_cyc : mark_cyc)), 32'(e.dly));
        end
        last_dat = tx_dat;
      end
      if (tx_done) begin
        if (grant != '0) chk("dat_hold", 32'(tx_dat), 32'(last_dat));
        done_cyc = cyc;
      end
      if (ack != '0) begin
        if (ack_q.size() == 0) chk("ack_unexpected", 32'(ack), 32'd0);
        else begin
          chk("ack_vec", 32'(ack), 32'(ack_q.pop_front()));
          chk("ack_lat", 32'(cyc - done_cyc), 32'd1);
        end
      end
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int k;
    rst = 1'b0;
    err_clr = 1'b0;
    tx_done_s = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_dat", 32'(tx_dat), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err_tout), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // All four requesting: order 0,1,2,3,0
    @(posedge clk); #1;
    load(0, 2, 8'h10, 8'h11, 8'h00, 0);
    load(1, 1, 8'h20, 8'h00, 8'h00, 0);
    load(2, 1, 8'h30, 8'h00, 8'h00, 0);
    load(3, 1, 8'h40, 8'h00, 8'h00, 0);
    mark_cyc = cyc;
    expect_byte(4'b0001, 8'h10, 1, 0, 1);
    expect_byte(4'b0010, 8'h20, 4, 1, 1);
    expect_byte(4'b0100, 8'h30, 4, 1, 1);
    expect_byte(4'b1000, 8'h40, 4, 1, 1);
    expect_byte(4'b0001, 8'h11, 4, 1, 1);
    drain(500);

    // Locked 3-byte burst from source 1, then 3 (pointer 2), then 0
    @(posedge clk); #1;
    load(0, 1, 8'h31, 8'h00, 8'h00, 0);
    load(1, 3, 8'h21, 8'h22, 8'h23, 1);
    load(3, 1, 8'h33, 8'h00, 8'h00, 0);
    mark_cyc = cyc;
    expect_byte(4'b0010, 8'h21, 1, 0, 1);
    expect_byte(4'b0010, 8'h22, 3, 1, 1);
    expect_byte(4'b0010, 8'h23, 3, 1, 1);
    expect_byte(4'b1000, 8'h33, 4, 1, 1);
    expect_byte(4'b0001, 8'h31, 4, 1, 1);
    drain(500);

    // Single source 2, long frame
    frame_len = 520;
    @(posedge clk); #1;
    load(2, 1, 8'hA5, 8'h00, 8'h00, 0);
    mark_cyc = cyc;
    expect_byte(4'b0100, 8'hA5, 1, 0, 1);
    drain(800);

    // Stalled transmitter: timeout on source 0, source 1 next, then 0 again
    frame_len = 10;
    @(posedge clk); #1;
    tx_mode = 1;
    load(0, 1, 8'h50, 8'h00, 8'h00, 0);
    load(1, 1, 8'h60, 8'h00, 8'h00, 0);
    mark_cyc = cyc;
    expect_byte(4'b0001, 8'h50, 1, 0, 0);
    expect_byte(4'b0010, 8'h60, -1, 0, 1);
    expect_byte(4'b0001, 8'h50, 4, 1, 1);
    wait_start(10);
    s = cyc;
    tx_mode = 0;
    k = 0;
    while (!err_tout && k < int'(TOUT) + 20) begin
      @(negedge clk);
      k++;
    end
    chk("tout_cycle", 32'(cyc), 32'(s + int'(TOUT) + 1));
    drain(1500);
    chk("err_sticky", 32'(err_tout), 32'd1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", 32'(err_tout), 32'd0);

    // tx_done on the exact timeout cycle: ack, no error
    frame_len = int'(TOUT);
    @(posedge clk); #1;
    load(2, 1, 8'h77, 8'h00, 8'h00, 0);
    mark_cyc = cyc;
    expect_byte(4'b0100, 8'h77, 1, 0, 1);
    drain(1500);
    chk("tie_no_err", 32'(err_tout), 32'd0);

    // Stray tx_done while idle
    frame_len = 10;
    @(posedge clk); #1 tx_done_s = 1'b1;
    @(posedge clk); #1 tx_done_s = 1'b0;
    @(negedge clk);
    chk("stray_ack", 32'(ack), 32'd0);
    chk("stray_start", 32'(tx_start), 32'd0);
    chk("stray_grant", 32'(grant), 32'd0);
    @(posedge clk); #1;
    load(3, 1, 8'h88, 8'h00, 8'h00, 0);
    mark_cyc = cyc;
    expect_byte(4'b1000, 8'h88, 1, 0, 1);
    drain(200);

    // Reset during WAIT: outputs clear at once, pointer restarts at 0
    @(posedge clk); #1;
    load(2, 1, 8'h99, 8'h00, 8'h00, 0);
    mark_cyc = cyc;
    expect_byte(4'b0100, 8'h99, 1, 0, 1);
    drain(200);
    frame_len = 520;
    @(posedge clk); #1;
    load(0, 1, 8'hAA, 8'h00, 8'h00, 0);
    mark_cyc = cyc;
    expect_byte(4'b0001, 8'hAA, 1, 0, 0);
    wait_start(10);
    load(1, 1, 8'hB1, 8'h00, 8'h00, 0);
    load(3, 1, 8'hB3, 8'h00, 8'h00, 0);
    repeat (10) @(negedge clk);
    chk("pre_rst_grant", 32'(grant), 32'b0001);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_start", 32'(tx_start), 32'd0);
    chk("arst_tx_dat", 32'(tx_dat), 32'd0);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    src_left[0] = 0;
    ack_q.delete();
    frame_len = 10;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mark_cyc = cyc;
    expect_byte(4'b0010, 8'hB1, 1, 0, 1);
    expect_byte(4'b1000, 8'hB3, 4, 1, 1);
    drain(300);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
